// File: rtl/e_md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: opcode encoding
// and the combinational arithmetic used at operation start.
package e_md_pkg;

    typedef enum logic [3:0] {
        MdNone  = 4'd0,
        MdMult  = 4'd1,
        MdMultu = 4'd2,
        MdDiv   = 4'd3,
        MdDivu  = 4'd4,
        MdMfhi  = 4'd5,
        MdMflo  = 4'd6,
        MdMthi  = 4'd7,
        MdMtlo  = 4'd8
    } md_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ok;  // low only for a divide by zero
    } md_res_t;

    function automatic logic is_md_start_op(input logic [3:0] op);
        return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MdDiv) || (op == MdDivu);
    endfunction

    function automatic md_res_t md_compute(input logic [3:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        md_res_t            res;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic        [63:0] up;
        res = '0;
        res.ok = 1'b1;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        sp = '0;
        sq = '0;
        sr = '0;
        up = '0;
        case (op)
            MdMult: begin
                sp = sa * sb;
                {res.hi, res.lo} = sp;
            end
            MdMultu: begin
                up = {32'h0, a} * {32'h0, b};
                {res.hi, res.lo} = up;
            end
            MdDiv: begin
                if (b == 32'h0) begin
                    res.ok = 1'b0;
                end else begin
                    // 64-bit operands keep INT_MIN / -1 well defined.
                    sq = sa / sb;
                    sr = sa % sb;
                    res.lo = 32'(sq);
                    res.hi = 32'(sr);
                end
            end
            MdDivu: begin
                if (b == 32'h0) begin
                    res.ok = 1'b0;
                end else begin
                    res.lo = a / b;
                    res.hi = a % b;
                end
            end
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/e_md.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div into shadow registers,
// committed to HI/LO when the busy counter expires; also serves MFHI/MFLO/MTHI/MTLO.
module e_md
    import e_md_pkg::*;
#(
    parameter int unsigned MultCycles = 5,
    parameter int unsigned DivCycles  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [3:0]  md_op_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic [31:0] md_result_o
);

    localparam int unsigned CntMax = (MultCycles > DivCycles) ? MultCycles : DivCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     hi_next_q, hi_next_d;
    logic [31:0]     lo_next_q, lo_next_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            div_zero_q, div_zero_d;
    logic            idle;
    md_res_t         res;

    assign idle = (cnt_q == '0);
    assign res  = md_compute(md_op_i, src_a_i, src_b_i);

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        hi_next_d  = hi_next_q;
        lo_next_d  = lo_next_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;
        if (idle) begin
            if (start_i && is_md_start_op(md_op_i)) begin
                hi_next_d  = res.hi;
                lo_next_d  = res.lo;
                div_zero_d = !res.ok;
                cnt_d      = is_div_op(md_op_i) ? CntW'(DivCycles) : CntW'(MultCycles);
            end else if (md_op_i == MdMthi) begin
                hi_d = src_a_i;
            end else if (md_op_i == MdMtlo) begin
                lo_d = src_a_i;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            // Divide by zero still occupies the unit but leaves HI/LO untouched.
            if (cnt_q == CntW'(1) && !div_zero_q) begin
                hi_d = hi_next_q;
                lo_d = lo_next_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q       <= '0;
            lo_q       <= '0;
            hi_next_q  <= '0;
            lo_next_q  <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            hi_next_q  <= hi_next_d;
            lo_next_q  <= lo_next_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy_o = !idle;

    always_comb begin
        md_result_o = '0;
        if (md_op_i == MdMfhi) begin
            md_result_o = hi_q;
        end else if (md_op_i == MdMflo) begin
            md_result_o = lo_q;
        end
    end

endmodule
